// File: rtl/bky_pkg.sv
// Package: bky_pkg
// Shared constants and helpers for the Buckeye load datapath.
//   WORD_W   : bits per configuration word (fixed at 16; CNT is 4 bits wide)
//   NWORDS   : words per full chain load
//   LOOP_W   : width of the word counter
//   CNT_W    : width of the bit counter
//   CNT_LAST : bit counter value when the last bit of a word is on the pins
//   loop_last: last word index for a load of nwords words
package bky_pkg;

  localparam int WORD_W = 16;
  localparam int NWORDS = 19;
  localparam int LOOP_W = 5;
  localparam int CNT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = 4'hF;

  function automatic logic [LOOP_W-1:0] loop_last(input int nwords);
    return LOOP_W'(nwords - 1);
  endfunction

endpackage

// File: rtl/bky_rbk_capture.sv
// Module: bky_rbk_capture
// Captures the serial return of the Buckeye chain into 16-bit words.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   discard any partial word and restart the bit count
//   sclk     in   chain strobe; dout is sampled on each posedge where it is high
//   dout     in   serial return from the chain, MSB first
//   rbk_data out  last completed word
//   rbk_we   out  one-cycle pulse when rbk_data holds a new word
module bky_rbk_capture
  import bky_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              sclk,
  input  logic              dout,
  output logic [WORD_W-1:0] rbk_data,
  output logic              rbk_we
);

  logic [WORD_W-1:0] shift_q;
  logic [CNT_W-1:0]  bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      rbk_data <= '0;
      rbk_we   <= 1'b0;
    end else begin
      rbk_we <= 1'b0;
      if (clr) begin
        bit_cnt <= '0;
      end else if (sclk) begin
        shift_q <= {shift_q[WORD_W-2:0], dout};
        bit_cnt <= bit_cnt + 1'b1;
        // The 16th sample completes the word; the counter wraps to 0 on its own.
        if (bit_cnt == CNT_LAST) begin
          rbk_data <= {shift_q[WORD_W-2:0], dout};
          rbk_we   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bky_shift_dp.sv
// Module: bky_shift_dp
// Datapath for the Buckeye load FSM: loads 16-bit config words from the
// FWFT load FIFO, shifts them MSB-first onto the chain, and reports the
// bit (CNT) and word (LOOP) counters back to the FSM. Holds the sticky
// DONE and UNDERRUN status.
// Optional feature macro: BKY_READBACK_EN adds capture of the chain's
// serial return into 16-bit readback words (RBK_DATA / RBK_WE).
// Ports:
//   CLK, RST_B     clock, asynchronous active-low reset
//   CLR_CNT        clear counters, status and first-word flag
//   RDENA          load FIFO_DOUT into the shift register
//   SHFT_ENA       shift the chain by one bit
//   SET_DONE       set sticky DONE
//   FIFO_DOUT      FIFO head word; FIFO_MT flags the FIFO empty
//   CNT, LOOP      bit index within word, word index within load
//   BKY_DIN        serial data to chain; BKY_SCLK one-cycle bit strobe
//   BKY_DOUT       serial return from chain (used only with readback)
//   DONE, UNDERRUN sticky status
//   RBK_DATA       readback word; RBK_WE one-cycle write strobe
module bky_shift_dp
  import bky_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_B,
  input  logic              CLR_CNT,
  input  logic              RDENA,
  input  logic              SHFT_ENA,
  input  logic              SET_DONE,
  input  logic [WORD_W-1:0] FIFO_DOUT,
  input  logic              FIFO_MT,
  output logic [CNT_W-1:0]  CNT,
  output logic [LOOP_W-1:0] LOOP,
  output logic              BKY_DIN,
  output logic              BKY_SCLK,
  input  logic              BKY_DOUT,
  output logic              DONE,
  output logic              UNDERRUN,
  output logic [WORD_W-1:0] RBK_DATA,
  output logic              RBK_WE
);

  localparam logic [LOOP_W-1:0] LOOP_LAST = loop_last(NWORDS);

  logic [WORD_W-1:0] sreg;
  // Set by the first load after a clear so that the first word keeps LOOP=0.
  logic              first_q;

  // NOTE: every state register is written with <= so all of them update
  // together from pre-edge values; blocking assignments here would make the
  // result depend on statement order.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      sreg     <= '0;
      first_q  <= 1'b0;
      CNT      <= '0;
      LOOP     <= '0;
      BKY_SCLK <= 1'b0;
      DONE     <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      // Strobe follows each load or shift that actually took effect.
      BKY_SCLK <= !CLR_CNT && (RDENA || SHFT_ENA);

      if (CLR_CNT) begin
        CNT      <= '0;
        LOOP     <= '0;
        first_q  <= 1'b0;
        DONE     <= 1'b0;
        UNDERRUN <= 1'b0;
      end else begin
        if (SET_DONE) DONE <= 1'b1;

        if (RDENA) begin
          sreg <= FIFO_MT ? '0 : FIFO_DOUT;
          CNT  <= '0;
          if (FIFO_MT) UNDERRUN <= 1'b1;
          if (!first_q) begin
            first_q <= 1'b1;
          end else if (LOOP == LOOP_LAST) begin
            // More loads than a chain holds is treated as an error.
            UNDERRUN <= 1'b1;
          end else begin
            LOOP <= LOOP + 1'b1;
          end
        end else if (SHFT_ENA) begin
          sreg <= {sreg[WORD_W-2:0], 1'b0};
          if (CNT != CNT_LAST) CNT <= CNT + 1'b1;
        end
      end
    end
  end

  assign BKY_DIN = sreg[WORD_W-1];

`ifdef BKY_READBACK_EN
  bky_rbk_capture u_rbk (
    .clk      (CLK),
    .rst_n    (RST_B),
    .clr      (CLR_CNT),
    .sclk     (BKY_SCLK),
    .dout     (BKY_DOUT),
    .rbk_data (RBK_DATA),
    .rbk_we   (RBK_WE)
  );
`else
  logic unused_dout;
  assign unused_dout = BKY_DOUT;
  assign RBK_DATA    = '0;
  assign RBK_WE      = 1'b0;
`endif

endmodule

// File: tb/tb_bky_shift_dp.sv
// Testbench for bky_shift_dp: directed vectors driven like the load FSM
// (inputs change on negedge), outputs sampled 1 time unit after posedge.
module tb_bky_shift_dp;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        clr_cnt, rdena, shft_ena, set_done, fifo_mt;
  logic [15:0] fifo_dout;
  logic [3:0]  cnt;
  logic [4:0]  loop_idx;
  logic        bky_din, bky_sclk, bky_dout, done, underrun;
  logic [15:0] rbk_data;
  logic        rbk_we;

  int checks   = 0;
  int failures = 0;
  int sclk_cnt = 0;
  int rbk_seen = 0;
  logic [15:0] exp_words [19];
  logic [15:0] seen;

  always #5 clk = ~clk;

  bky_shift_dp dut (
    .CLK(clk), .RST_B(rst_b), .CLR_CNT(clr_cnt), .RDENA(rdena),
    .SHFT_ENA(shft_ena), .SET_DONE(set_done), .FIFO_DOUT(fifo_dout),
    .FIFO_MT(fifo_mt), .CNT(cnt), .LOOP(loop_idx), .BKY_DIN(bky_din),
    .BKY_SCLK(bky_sclk), .BKY_DOUT(bky_dout), .DONE(done),
    .UNDERRUN(underrun), .RBK_DATA(rbk_data), .RBK_WE(rbk_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Chain loopback: half-cycle register so the sample at each strobe sees the bit on the pins.
  always @(negedge clk) bky_dout <= bky_din;

  always @(posedge clk) if (bky_sclk === 1'b1) sclk_cnt++;

  always @(posedge clk) begin
    if (rbk_we === 1'b1) begin
`ifdef BKY_READBACK_EN
      if (rbk_seen < 19) check("rbk_data", {16'h0, rbk_data}, {16'h0, exp_words[rbk_seen]});
`endif
      rbk_seen++;
    end
  end

  task automatic step(input logic clr, input logic rd, input logic sh, input logic sd,
                      input logic [15:0] d, input logic mt);
    @(negedge clk);
    clr_cnt = clr; rdena = rd; shft_ena = sh; set_done = sd; fifo_dout = d; fifo_mt = mt;
    @(posedge clk);
    #1;
    clr_cnt = 0; rdena = 0; shft_ena = 0; set_done = 0; fifo_mt = 0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic mt, output logic [15:0] obs);
    step(0, 1, 0, 0, w, mt);
    obs[15] = bky_din;
    for (int k = 14; k >= 0; k--) begin
      step(0, 0, 1, 0, 16'h0, 0);
      obs[k] = bky_din;
    end
  endtask

  initial begin
    rst_b = 0; clr_cnt = 0; rdena = 0; shft_ena = 0; set_done = 0;
    fifo_mt = 0; fifo_dout = 16'h0;
    for (int i = 0; i < 19; i++) exp_words[i] = 16'(i * 16'h1357) ^ 16'hA5A5;

    // Reset held with random inputs.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {clr_cnt, rdena, shft_ena, set_done, fifo_mt} = 5'($urandom);
      fifo_dout = 16'($urandom);
    end
    @(posedge clk); #1;
    check("rst_cnt_loop", {23'h0, cnt, loop_idx}, 32'h0);
    check("rst_flags", {27'h0, bky_din, bky_sclk, done, underrun, rbk_we}, 32'h0);
    check("rst_rbk_data", {16'h0, rbk_data}, 32'h0);
    @(negedge clk);
    clr_cnt = 0; rdena = 0; shft_ena = 0; set_done = 0; fifo_mt = 0;
    rst_b = 1;

    // Release mid-shift: reset in the middle of a word.
    step(1, 0, 0, 0, 16'h0, 0);
    step(0, 1, 0, 0, 16'hFFFF, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 16'h0, 0);
    check("pre_rst_cnt", {28'h0, cnt}, 32'd5);
    #2 rst_b = 0;
    #1 check("mid_rst_cnt_loop", {23'h0, cnt, loop_idx}, 32'h0);
    @(negedge clk); rst_b = 1;
    rbk_seen = 0;
    repeat (20) step(0, 0, 0, 0, 16'h0, 0);
    check("mid_rst_no_rbk_we", rbk_seen, 0);

    // Single word.
    step(1, 0, 0, 0, 16'h0, 0);
    sclk_cnt = 0;
    send_word(16'hA5C3, 0, seen);
    check("single_din_seq", {16'h0, seen}, 32'hA5C3);
    check("single_cnt", {28'h0, cnt}, 32'd15);
    check("single_loop", {27'h0, loop_idx}, 32'd0);
    step(0, 0, 0, 0, 16'h0, 0);
    check("single_strobes", sclk_cnt, 16);

    // Full load of 19 words.
    step(1, 0, 0, 0, 16'h0, 0);
    sclk_cnt = 0;
    rbk_seen = 0;
    for (int i = 0; i < 19; i++) begin
      send_word(exp_words[i], 0, seen);
      check($sformatf("full_word%0d", i), {16'h0, seen}, {16'h0, exp_words[i]});
      check($sformatf("full_loop%0d", i), {27'h0, loop_idx}, i);
    end
    check("full_last_cnt", {28'h0, cnt}, 32'd15);
    step(0, 0, 0, 1, 16'h0, 0);
    check("full_done", {31'h0, done}, 32'd1);
    check("full_strobes", sclk_cnt, 304);
    check("full_no_underrun", {31'h0, underrun}, 32'd0);
    step(0, 0, 0, 0, 16'h0, 0);
`ifdef BKY_READBACK_EN
    check("rbk_we_count", rbk_seen, 19);
`else
    check("rbk_we_count", rbk_seen, 0);
`endif

    // Underrun on word 5.
    step(1, 0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 5; i++) send_word(exp_words[i], 0, seen);
    check("ur_before", {31'h0, underrun}, 32'd0);
    send_word(16'hBEEF, 1, seen);
    check("ur_sreg_zero", {16'h0, seen}, 32'h0);
    check("ur_flag", {31'h0, underrun}, 32'd1);
    check("ur_loop", {27'h0, loop_idx}, 32'd5);
    send_word(exp_words[6], 0, seen);
    check("ur_sticky", {31'h0, underrun}, 32'd1);

    // 20th load at saturation.
    step(1, 0, 0, 0, 16'h0, 0);
    check("clr_underrun", {31'h0, underrun}, 32'd0);
    for (int i = 0; i < 19; i++) send_word(exp_words[i], 0, seen);
    check("ovr_before", {27'h0, loop_idx, underrun}, {26'h0, 5'd18, 1'b0});
    send_word(16'h1234, 0, seen);
    check("ovr_loop_sat", {27'h0, loop_idx}, 32'd18);
    check("ovr_underrun", {31'h0, underrun}, 32'd1);

    // CLR_CNT mid-load.
    step(1, 0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 8; i++) send_word(exp_words[i], 0, seen);
    step(0, 1, 0, 1, 16'hC0DE, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 16'h0, 0);
    check("mid_state", {22'h0, loop_idx, cnt, done}, {22'h0, 5'd8, 4'd9, 1'b1});
    step(1, 0, 0, 0, 16'h0, 0);
    check("mid_clr", {22'h0, loop_idx, cnt, done}, 32'h0);
    step(0, 1, 0, 0, 16'h5A5A, 0);
    check("mid_reload", {23'h0, loop_idx, cnt}, 32'h0);
    check("mid_reload_din", {31'h0, bky_din}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
